// File: rtl/instr_encoder_pkg.sv
// instr_encoder_pkg: opcode map, condition/error codes, FSM states and immediate range helpers.
package instr_encoder_pkg;
    localparam logic [3:0] OP_ADD    = 4'h0;
    localparam logic [3:0] OP_PADDSB = 4'h1;
    localparam logic [3:0] OP_SUB    = 4'h2;
    localparam logic [3:0] OP_AND    = 4'h3;
    localparam logic [3:0] OP_NOR    = 4'h4;
    localparam logic [3:0] OP_SLL    = 4'h5;
    localparam logic [3:0] OP_SRL    = 4'h6;
    localparam logic [3:0] OP_SRA    = 4'h7;
    localparam logic [3:0] OP_LW     = 4'h8;
    localparam logic [3:0] OP_SW     = 4'h9;
    localparam logic [3:0] OP_LHB    = 4'hA;
    localparam logic [3:0] OP_LLB    = 4'hB;
    localparam logic [3:0] OP_B      = 4'hC;
    localparam logic [3:0] OP_JAL    = 4'hD;
    localparam logic [3:0] OP_JR     = 4'hE;
    localparam logic [3:0] OP_HLT    = 4'hF;

    localparam logic [2:0] COND_UNCOND = 3'b111;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_RANGE = 2'b01;
    localparam logic [1:0] ERR_RSVD  = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_ACCEPT, S_WRITE, S_DONE} state_e;

    // Signed n-bit fit: every bit from n-1 upward must match the sign.
    function automatic logic fits_s(input logic [15:0] v, input int n);
        logic [15:0] m;
        m = 16'hFFFF << (n - 1);
        return ((v & m) == 16'h0) || ((v & m) == m);
    endfunction

    function automatic logic fits_u(input logic [15:0] v, input int n);
        return (v & (16'hFFFF << n)) == 16'h0;
    endfunction
endpackage

// File: rtl/instr_encoder_field_pack.sv
// instr_field_pack: packs request fields into a 16-bit word and flags range/reserved-field violations.
module instr_field_pack
    import instr_encoder_pkg::*;
(
    input  logic [3:0]  opcode,
    input  logic [3:0]  rd,
    input  logic [3:0]  rs,
    input  logic [3:0]  rt,
    input  logic [2:0]  cond,
    input  logic [15:0] imm,
    output logic [15:0] word,
    output logic        legal,
    output logic [1:0]  err_code
);
    always_comb begin
        word     = {opcode, rd, rs, rt};
        err_code = ERR_NONE;
        case (opcode)
            OP_SLL, OP_SRL, OP_SRA: begin
                word     = {opcode, rd, rs, imm[3:0]};
                err_code = fits_u(imm, 4) ? ERR_NONE : ERR_RANGE;
            end
            OP_LW: begin
                word     = {opcode, rd, rs, imm[3:0]};
                err_code = fits_s(imm, 4) ? ERR_NONE : ERR_RANGE;
            end
            OP_SW: begin
                word     = {opcode, rt, rs, imm[3:0]};
                err_code = fits_s(imm, 4) ? ERR_NONE : ERR_RANGE;
            end
            OP_LHB: begin
                word     = {opcode, rd, imm[7:0]};
                err_code = fits_u(imm, 8) ? ERR_NONE : ERR_RANGE;
            end
            OP_LLB: begin
                word     = {opcode, rd, imm[7:0]};
                err_code = fits_s(imm, 8) ? ERR_NONE : ERR_RANGE;
            end
            OP_B: begin
                word     = {opcode, cond, imm[8:0]};
                err_code = fits_s(imm, 9) ? ERR_NONE : ERR_RANGE;
            end
            OP_JAL: begin
                word     = {opcode, imm[11:0]};
                err_code = !fits_s(imm, 12) ? ERR_RANGE : (rd != 4'hF) ? ERR_RSVD : ERR_NONE;
            end
            OP_JR: begin
                word     = {opcode, 4'h0, rs, 4'h0};
                err_code = (|{rd, rt, cond, imm}) ? ERR_RSVD : ERR_NONE;
            end
            OP_HLT: begin
                word     = 16'hF000;
                err_code = (|{rd, rs, rt, cond, imm}) ? ERR_RSVD : ERR_NONE;
            end
            default: ;
        endcase
        legal = err_code == ERR_NONE;
    end
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: accepts instruction field requests, encodes them and writes them to instruction memory.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_opcode,
    input  logic [3:0]        in_rd,
    input  logic [3:0]        in_rs,
    input  logic [3:0]        in_rt,
    input  logic [2:0]        in_cond,
    input  logic [15:0]       in_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wdata,
    input  logic              imem_ack,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [15:0]       count,
    output logic              done
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic [15:0]       count_q, count_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [1:0]        err_code_q, err_code_d;
    logic [15:0]       pack_word;
    logic              pack_legal;
    logic [1:0]        pack_err;

    instr_field_pack u_pack (
        .opcode   (in_opcode),
        .rd       (in_rd),
        .rs       (in_rs),
        .rt       (in_rt),
        .cond     (in_cond),
        .imm      (in_imm),
        .word     (pack_word),
        .legal    (pack_legal),
        .err_code (pack_err)
    );

    // start masks in_ready so a simultaneous request is left pending
    assign in_ready   = (state_q == S_ACCEPT) && !start;
    assign imem_we    = state_q == S_WRITE;
    assign imem_addr  = ptr_q;
    assign imem_wdata = wdata_q;
    assign err        = err_q;
    assign err_code   = err_code_q;
    assign count      = count_q;
    assign done       = done_q;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        wdata_d    = wdata_q;
        count_d    = count_q;
        done_d     = done_q;
        err_d      = 1'b0;
        err_code_d = ERR_NONE;
        if (start) begin
            state_d = S_ACCEPT;
            ptr_d   = base_addr;
            count_d = 16'h0;
            done_d  = 1'b0;
        end else if (state_q == S_ACCEPT && in_valid) begin
            state_d    = pack_legal ? S_WRITE : S_ACCEPT;
            wdata_d    = pack_legal ? pack_word : wdata_q;
            err_d      = !pack_legal;
            err_code_d = pack_err;
        end else if (state_q == S_WRITE && imem_ack) begin
            state_d = (wdata_q[15:12] == OP_HLT) ? S_DONE : S_ACCEPT;
            done_d  = wdata_q[15:12] == OP_HLT;
            ptr_d   = ptr_q + ADDR_W'(1);
            count_d = count_q + 16'(count_q != 16'hFFFF);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            wdata_q    <= 16'h0;
            count_q    <= 16'h0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            wdata_q    <= wdata_d;
            count_q    <= count_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: scenario tasks with a write scoreboard checked whenever imem_we meets imem_ack.
module tb_instr_encoder;
    import instr_encoder_pkg::*;
    localparam int AW = 16;

    logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0, imem_ack = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [3:0]    in_opcode = '0, in_rd = '0, in_rs = '0, in_rt = '0;
    logic [2:0]    in_cond = '0;
    logic [15:0]   in_imm = '0;
    logic          in_ready, imem_we, err, done;
    logic [AW-1:0] imem_addr;
    logic [15:0]   imem_wdata, count;
    logic [1:0]    err_code;

    int checks = 0, errors = 0;
    logic [AW+15:0] exp_q[$];
    logic [AW+15:0] mon_e;

    instr_encoder #(.ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
        .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt), .in_cond(in_cond), .in_imm(in_imm),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata), .imem_ack(imem_ack),
        .err(err), .err_code(err_code), .count(count), .done(done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && imem_we && imem_ack) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL write_unexpected got addr=%h data=%h, none expected", imem_addr, imem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                if ({imem_addr, imem_wdata} !== mon_e) begin
                    errors++;
                    $display("FAIL write got addr=%h data=%h expected addr=%h data=%h",
                             imem_addr, imem_wdata, mon_e[AW+15:16], mon_e[15:0]);
                end
            end
        end
    end

    task automatic expect_write(input logic [AW-1:0] a, input logic [15:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic do_start(input logic [AW-1:0] b);
        @(posedge clk); #1;
        base_addr = b;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [3:0] op, rd, rs, rt, input logic [2:0] cond, input logic [15:0] imm);
        int n;
        @(posedge clk); #1;
        in_opcode = op; in_rd = rd; in_rs = rs; in_rt = rt; in_cond = cond; in_imm = imm;
        in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 20);
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL send_ready got in_ready=%b expected 1 within 20 cycles", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_we();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!imem_we && n < 20);
        checks++;
        if (!imem_we) begin
            errors++;
            $display("FAIL wait_we got imem_we=%b expected 1 within 20 cycles", imem_we);
        end
    endtask

    task automatic ack_write();
        wait_we();
        @(posedge clk); #1;
        imem_ack = 1'b1;
        @(posedge clk); #1;
        imem_ack = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({imem_we, imem_addr, imem_wdata, err, err_code, count, done, in_ready} !== '0) begin
            errors++;
            $display("FAIL reset_state got we=%b addr=%h wdata=%h err=%b code=%b count=%h done=%b rdy=%b expected all 0",
                     imem_we, imem_addr, imem_wdata, err, err_code, count, done, in_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_ready got %b expected 0", in_ready);
        end
    endtask

    task automatic test_add();
        do_start(16'h0040);
        expect_write(16'h0040, 16'h0123);
        send(OP_ADD, 4'h1, 4'h2, 4'h3, 3'h0, 16'h0);
        ack_write();
        @(negedge clk);
        checks++;
        if (count !== 16'd1 || imem_we !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL add_after got count=%h we=%b rdy=%b expected 0001 0 1", count, imem_we, in_ready);
        end
    endtask

    task automatic test_lw();
        expect_write(16'h0041, 16'h8458);
        send(OP_LW, 4'h4, 4'h5, 4'h0, 3'h0, 16'hFFF8);
        ack_write();
        send(OP_LW, 4'h4, 4'h5, 4'h0, 3'h0, 16'h0008);
        @(negedge clk);
        checks++;
        if (err !== 1'b1 || err_code !== ERR_RANGE || imem_we !== 1'b0) begin
            errors++;
            $display("FAIL lw_range got err=%b code=%b we=%b expected 1 01 0", err, err_code, imem_we);
        end
        @(negedge clk);
        checks++;
        if (err !== 1'b0 || count !== 16'd2 || imem_addr !== 16'h0042) begin
            errors++;
            $display("FAIL lw_reject_state got err=%b count=%h addr=%h expected 0 0002 0042", err, count, imem_addr);
        end
    endtask

    task automatic test_b_jal();
        logic [3:0]  t_op  [0:8] = '{OP_SLL, OP_LW, OP_SW, OP_LHB, OP_LLB, OP_B, OP_JAL, OP_JAL, OP_HLT};
        logic [3:0]  t_rd  [0:8] = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'hF, 4'h3, 4'h0};
        logic [15:0] t_imm [0:8] = '{16'h0010, 16'hFFF7, 16'h0008, 16'h0100, 16'hFF7F, 16'h0100, 16'h0800, 16'h0000, 16'h0001};
        logic [1:0]  t_code[0:8] = '{ERR_RANGE, ERR_RANGE, ERR_RANGE, ERR_RANGE, ERR_RANGE, ERR_RANGE, ERR_RANGE, ERR_RSVD, ERR_RSVD};
        expect_write(16'h0042, 16'hCFFF);
        send(OP_B, 4'h0, 4'h0, 4'h0, COND_UNCOND, 16'hFFFF);
        ack_write();
        expect_write(16'h0043, 16'hE050);
        send(OP_JR, 4'h0, 4'h5, 4'h0, 3'h0, 16'h0);
        ack_write();
        for (int i = 0; i < 9; i++) begin
            send(t_op[i], t_rd[i], 4'h2, 4'h0, 3'h0, t_imm[i]);
            @(negedge clk);
            checks++;
            if (err !== 1'b1 || err_code !== t_code[i] || imem_we !== 1'b0) begin
                errors++;
                $display("FAIL reject_%0d got err=%b code=%b we=%b expected 1 %b 0", i, err, err_code, imem_we, t_code[i]);
            end
        end
        send(OP_JR, 4'h0, 4'h5, 4'h1, 3'h0, 16'h0);
        @(negedge clk);
        checks++;
        if (err !== 1'b1 || err_code !== ERR_RSVD) begin
            errors++;
            $display("FAIL jr_rsvd got err=%b code=%b expected 1 10", err, err_code);
        end
    endtask

    task automatic test_stall();
        expect_write(16'h0044, 16'h0ABC);
        send(OP_ADD, 4'hA, 4'hB, 4'hC, 3'h0, 16'h0);
        wait_we();
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (imem_we !== 1'b1 || imem_addr !== 16'h0044 || imem_wdata !== 16'h0ABC || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_%0d got we=%b addr=%h wdata=%h rdy=%b expected 1 0044 0abc 0",
                         i, imem_we, imem_addr, imem_wdata, in_ready);
            end
        end
        @(posedge clk); #1;
        imem_ack = 1'b1;
        @(posedge clk); #1;
        imem_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (count !== 16'd5) begin
            errors++;
            $display("FAIL stall_count got %h expected 0005", count);
        end
    endtask

    task automatic test_wrap();
        do_start(16'hFFFF);
        expect_write(16'hFFFF, 16'h512F);
        send(OP_SLL, 4'h1, 4'h2, 4'h0, 3'h0, 16'h000F);
        ack_write();
        expect_write(16'h0000, 16'hA3FF);
        send(OP_LHB, 4'h3, 4'h0, 4'h0, 3'h0, 16'h00FF);
        ack_write();
        @(negedge clk);
        checks++;
        if (count !== 16'd2 || imem_addr !== 16'h0001) begin
            errors++;
            $display("FAIL wrap got count=%h addr=%h expected 0002 0001", count, imem_addr);
        end
    endtask

    task automatic test_hlt();
        expect_write(16'h0001, 16'hF000);
        send(OP_HLT, 4'h0, 4'h0, 4'h0, 3'h0, 16'h0);
        ack_write();
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || in_ready !== 1'b0 || count !== 16'd3) begin
            errors++;
            $display("FAIL hlt_done got done=%b rdy=%b count=%h expected 1 0 0003", done, in_ready, count);
        end
        @(posedge clk); #1;
        imem_ack = 1'b1;
        @(posedge clk); #1;
        imem_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (count !== 16'd3 || imem_addr !== 16'h0002) begin
            errors++;
            $display("FAIL stray_ack got count=%h addr=%h expected 0003 0002", count, imem_addr);
        end
        do_start(16'h0010);
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || in_ready !== 1'b1 || count !== 16'd0 || imem_addr !== 16'h0010) begin
            errors++;
            $display("FAIL restart got done=%b rdy=%b count=%h addr=%h expected 0 1 0000 0010", done, in_ready, count, imem_addr);
        end
    endtask

    task automatic test_start_priority();
        @(posedge clk); #1;
        base_addr = 16'h0200;
        start = 1'b1;
        in_opcode = OP_ADD; in_rd = 4'h7; in_rs = 4'h7; in_rt = 4'h7; in_imm = 16'h0;
        in_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL start_ready got %b expected 0", in_ready);
        end
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_we !== 1'b0 || imem_addr !== 16'h0200 || err !== 1'b0) begin
            errors++;
            $display("FAIL start_wins got we=%b addr=%h err=%b expected 0 0200 0", imem_we, imem_addr, err);
        end
        send(OP_ADD, 4'h1, 4'h1, 4'h1, 3'h0, 16'h0);
        wait_we();
        do_start(16'h0300);
        @(negedge clk);
        checks++;
        if (imem_we !== 1'b0 || imem_addr !== 16'h0300 || count !== 16'd0) begin
            errors++;
            $display("FAIL abort got we=%b addr=%h count=%h expected 0 0300 0000", imem_we, imem_addr, count);
        end
    endtask

    task automatic test_reset_mid_write();
        expect_write(16'h0300, 16'h2456);
        send(OP_SUB, 4'h4, 4'h5, 4'h6, 3'h0, 16'h0);
        ack_write();
        send(OP_ADD, 4'h1, 4'h2, 4'h3, 3'h0, 16'h0);
        wait_we();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({imem_we, imem_addr, imem_wdata, err, err_code, count, done, in_ready} !== '0) begin
            errors++;
            $display("FAIL reset_mid_write got we=%b addr=%h wdata=%h err=%b code=%b count=%h done=%b rdy=%b expected all 0",
                     imem_we, imem_addr, imem_wdata, err, err_code, count, done, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_add();
        test_lw();
        test_b_jal();
        test_stall();
        test_wrap();
        test_hlt();
        test_start_priority();
        test_reset_mid_write();
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
